// File: rtl/fwd_hazard_tracker.sv
// Decode-stage forwarding/hazard unit with an internal EX..WB write scoreboard.
// Optional FWD_STATS_EN adds saturating stall/forward cycle counters.
module fwd_hazard_lane #(
    parameter int REG_AW   = 5,
    parameter int DEPTH    = 3,
    parameter int LD_READY = 2,
    parameter int SEL_W    = 2
) (
    input  logic [REG_AW-1:0]          src,
    input  logic                       used,
    input  logic [DEPTH:1]             sb_v,
    input  logic [DEPTH:1][REG_AW-1:0] sb_rd,
    input  logic [DEPTH:1]             sb_ld,
    output logic [SEL_W-1:0]           sel,
    output logic                       hazard
);
    logic win_ld;

    // Scan oldest to youngest so the youngest matching stage overwrites.
    always_comb begin
        sel    = '0;
        win_ld = 1'b0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (used && (src != '0) && sb_v[k] && (sb_rd[k] == src)) begin
                sel    = SEL_W'(k);
                win_ld = sb_ld[k];
            end
        end
        hazard = win_ld && (sel < SEL_W'(LD_READY));
    end
endmodule

module fwd_hazard_tracker #(
    parameter int REG_AW   = 5,
    parameter int NUM_SRC  = 2,
    parameter int DEPTH    = 3,
    parameter int LD_READY = 2,
    parameter int SEL_W    = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      id_valid,
    input  logic                      id_regwr,
    input  logic                      id_memrd,
    input  logic [REG_AW-1:0]         id_rd,
    input  logic [NUM_SRC*REG_AW-1:0] id_src,
    input  logic [NUM_SRC-1:0]        id_src_used,
    input  logic                      flush,
    output logic                      stall,
`ifdef FWD_STATS_EN
    output logic [15:0]               stall_cnt,
    output logic [15:0]               fwd_cnt,
`endif
    output logic [NUM_SRC*SEL_W-1:0]  fwd_sel
);
    logic [DEPTH:1]             vld_pipe;
    logic [DEPTH:1][REG_AW-1:0] rd_pipe;
    logic [DEPTH:1]             ld_pipe;
    logic [NUM_SRC-1:0]         hazard;
    logic                       ins;

    assign ins   = id_valid && id_regwr && (id_rd != '0) && !stall && !flush;
    assign stall = id_valid && !flush && (|hazard);

    // Entry k is stage k after ID; a stalled or squashed decode becomes a bubble.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_pipe <= '0;
            rd_pipe  <= '0;
            ld_pipe  <= '0;
        end else begin
            vld_pipe <= {vld_pipe[DEPTH-1:1], ins};
            rd_pipe  <= {rd_pipe[DEPTH-1:1], (ins ? id_rd : {REG_AW{1'b0}})};
            ld_pipe  <= {ld_pipe[DEPTH-1:1], (ins && id_memrd)};
        end
    end

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_lane
        fwd_hazard_lane #(
            .REG_AW  (REG_AW),
            .DEPTH   (DEPTH),
            .LD_READY(LD_READY),
            .SEL_W   (SEL_W)
        ) u_lane (
            .src   (id_src[i*REG_AW +: REG_AW]),
            .used  (id_src_used[i]),
            .sb_v  (vld_pipe),
            .sb_rd (rd_pipe),
            .sb_ld (ld_pipe),
            .sel   (fwd_sel[i*SEL_W +: SEL_W]),
            .hazard(hazard[i])
        );
    end

`ifdef FWD_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
            fwd_cnt   <= '0;
        end else if (id_valid) begin
            if (stall && (stall_cnt != 16'hFFFF))
                stall_cnt <= stall_cnt + 16'd1;
            if (!stall && (|fwd_sel) && (fwd_cnt != 16'hFFFF))
                fwd_cnt <= fwd_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_fwd_hazard_tracker.sv
// Directed bench for fwd_hazard_tracker: default instance plus an LD_READY=3 instance.
module tb_fwd_hazard_tracker;
    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid, id_regwr, id_memrd, flush;
    logic [4:0] id_rd;
    logic [9:0] id_src;
    logic [1:0] id_src_used;
    logic       stall, stall3;
    logic [3:0] fwd_sel, fwd_sel3;
`ifdef FWD_STATS_EN
    logic [15:0] stall_cnt, fwd_cnt, stall_cnt3, fwd_cnt3;
`endif
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fwd_hazard_tracker u_dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_regwr(id_regwr),
        .id_memrd(id_memrd), .id_rd(id_rd), .id_src(id_src), .id_src_used(id_src_used),
        .flush(flush), .stall(stall),
`ifdef FWD_STATS_EN
        .stall_cnt(stall_cnt), .fwd_cnt(fwd_cnt),
`endif
        .fwd_sel(fwd_sel)
    );

    fwd_hazard_tracker #(.LD_READY(3)) u_dut3 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_regwr(id_regwr),
        .id_memrd(id_memrd), .id_rd(id_rd), .id_src(id_src), .id_src_used(id_src_used),
        .flush(flush), .stall(stall3),
`ifdef FWD_STATS_EN
        .stall_cnt(stall_cnt3), .fwd_cnt(fwd_cnt3),
`endif
        .fwd_sel(fwd_sel3)
    );

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Apply one decode slot; outputs settle 1ns later.
    task automatic drv(input logic v, input logic rw, input logic ld, input logic [4:0] rd,
                       input logic [4:0] s0, input logic [4:0] s1, input logic [1:0] used,
                       input logic fl);
        id_valid = v; id_regwr = rw; id_memrd = ld; id_rd = rd;
        id_src = {s1, s0}; id_src_used = used; flush = fl;
        #1;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        drv(0, 0, 0, 0, 0, 0, 2'b00, 0);
        repeat (3) cyc();
    endtask

    initial begin
        reset = 1'b0;
        // reset held low with random decode traffic
        for (int i = 0; i < 4; i++) begin
            drv(1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom),
                5'($urandom), 5'($urandom), 2'($urandom), 1'($urandom));
            chk("rst_stall", 16'(stall), 16'h0);
            chk("rst_sel", 16'(fwd_sel), 16'h0);
            cyc();
        end
        reset = 1'b1;
        drv(1, 0, 0, 0, 3, 5, 2'b11, 0);
        chk("rel_sel", 16'(fwd_sel), 16'h0);
        chk("rel_stall", 16'(stall), 16'h0);

        // ALU chain with 0..3 intervening nops
        for (int n = 0; n < 4; n++) begin
            drain();
            drv(1, 1, 0, 3, 0, 0, 2'b00, 0);
            cyc();
            for (int j = 0; j < n; j++) begin
                drv(1, 0, 0, 0, 0, 0, 2'b00, 0);
                cyc();
            end
            drv(1, 1, 0, 4, 3, 3, 2'b11, 0);
            case (n)
                0: chk("alu_sel_d0", 16'(fwd_sel), 16'h5);
                1: chk("alu_sel_d1", 16'(fwd_sel), 16'hA);
                2: chk("alu_sel_d2", 16'(fwd_sel), 16'hF);
                default: chk("alu_sel_d3", 16'(fwd_sel), 16'h0);
            endcase
            chk("alu_stall", 16'(stall), 16'h0);
        end

        // load-use, LD_READY=2 and LD_READY=3
        drain();
        drv(1, 1, 1, 5, 0, 0, 2'b00, 0);
        chk("lw_stall", 16'(stall), 16'h0);
        cyc();
        drv(1, 1, 0, 6, 5, 0, 2'b11, 0);
        chk("lu_stall_a", 16'(stall), 16'h1);
        chk("lu_sel_a", 16'(fwd_sel), 16'h1);
        chk("lu3_stall_a", 16'(stall3), 16'h1);
        cyc();
        chk("lu_stall_b", 16'(stall), 16'h0);
        chk("lu_sel_b", 16'(fwd_sel), 16'h2);
        chk("lu3_stall_b", 16'(stall3), 16'h1);
        chk("lu3_sel_b", 16'(fwd_sel3), 16'h2);
        cyc();
        chk("lu3_stall_c", 16'(stall3), 16'h0);
        chk("lu3_sel_c", 16'(fwd_sel3), 16'h3);

        // youngest producer wins over an older load
        drain();
        drv(1, 1, 1, 7, 0, 0, 2'b00, 0);
        cyc();
        drv(1, 1, 0, 7, 0, 0, 2'b00, 0);
        cyc();
        drv(1, 0, 0, 0, 7, 7, 2'b11, 0);
        chk("prio_sel", 16'(fwd_sel), 16'h5);
        chk("prio_stall", 16'(stall), 16'h0);

        // load into $0 is never tracked
        drain();
        drv(1, 1, 1, 0, 0, 0, 2'b00, 0);
        cyc();
        drv(1, 0, 0, 0, 0, 0, 2'b11, 0);
        chk("r0_sel", 16'(fwd_sel), 16'h0);
        chk("r0_stall", 16'(stall), 16'h0);

        // flush beats stall and leaves a bubble in EX
        drain();
        drv(1, 1, 1, 5, 0, 0, 2'b00, 0);
        cyc();
        drv(1, 1, 0, 6, 5, 0, 2'b11, 1);
        chk("fl_stall", 16'(stall), 16'h0);
        chk("fl_sel", 16'(fwd_sel), 16'h1);
        cyc();
        drv(1, 0, 0, 0, 6, 5, 2'b11, 0);
        chk("fl_bubble", 16'(fwd_sel), 16'h8);

        // unused operands and invalid decode never stall
        drain();
        drv(1, 1, 1, 5, 0, 0, 2'b00, 0);
        cyc();
        drv(1, 1, 0, 6, 5, 5, 2'b00, 0);
        chk("unused_stall", 16'(stall), 16'h0);
        chk("unused_sel", 16'(fwd_sel), 16'h0);
        drv(0, 1, 0, 6, 5, 5, 2'b11, 0);
        chk("inval_stall", 16'(stall), 16'h0);

        // async reset in the middle of a load-use stall
        drain();
        drv(1, 1, 1, 5, 0, 0, 2'b00, 0);
        cyc();
        drv(1, 1, 0, 6, 5, 0, 2'b11, 0);
        chk("mid_stall_pre", 16'(stall), 16'h1);
        reset = 1'b0;
        #1;
        chk("mid_stall_rst", 16'(stall), 16'h0);
        chk("mid_sel_rst", 16'(fwd_sel), 16'h0);
        cyc();
        reset = 1'b1;
        #1;
        chk("mid_sel_rel", 16'(fwd_sel), 16'h0);
        chk("mid_stall_rel", 16'(stall), 16'h0);

`ifdef FWD_STATS_EN
        reset = 1'b0;
        #1;
        chk("cnt_rst", stall_cnt | fwd_cnt, 16'h0);
        reset = 1'b1;
        drv(0, 0, 0, 0, 0, 0, 2'b00, 0);
        cyc();
        // three load-use pairs: one stall and one forward cycle each
        for (int r = 0; r < 3; r++) begin
            drv(1, 1, 1, 5, 0, 0, 2'b00, 0);
            cyc();
            drv(1, 1, 0, 6, 5, 0, 2'b01, 0);
            cyc();
            cyc();
        end
        drv(1, 1, 0, 8, 0, 0, 2'b00, 0);
        cyc();
        drv(1, 0, 0, 0, 8, 0, 2'b01, 0);
        cyc();
        drv(0, 0, 0, 0, 8, 0, 2'b01, 0);
        cyc();
        chk("stall_cnt", stall_cnt, 16'd3);
        chk("fwd_cnt", fwd_cnt, 16'd4);
        // back-to-back self-dependent ALU ops forward every cycle until saturation
        drv(1, 1, 0, 9, 0, 0, 2'b00, 0);
        cyc();
        drv(1, 1, 0, 9, 9, 9, 2'b11, 0);
        repeat (65540) cyc();
        chk("fwd_sat", fwd_cnt, 16'hFFFF);
        chk("stall_hold", stall_cnt, 16'd3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
